// File: rtl/banked_ram_pkg.sv
// banked_ram_pkg -- shared types and helpers for banked_sync_ram.
//
// Contents:
//   ram_state_e  : controller state (CLEAR sweeps every row to zero after
//                  reset, IDLE serves requests).
//   even_parity  : even-parity bit of a word, zero-extended to PARITY_MAX_W.
//
// Optional feature macro used by the design: BANKED_RAM_PARITY_EN.
package banked_ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } ram_state_e;

  // Widest word the parity helper covers. Zero-extension leaves the XOR
  // reduction unchanged, so narrower words are simply cast up.
  localparam int PARITY_MAX_W = 64;

  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/ram_bank.sv
// ram_bank -- one single-port synchronous RAM bank.
//
// Parameters:
//   ROW_WIDTH  : row address width, bank holds 2**ROW_WIDTH words
//   WORD_WIDTH : stored word width (data plus optional parity bit)
//
// Ports:
//   clk    in   clock, all activity on the rising edge
//   rst    in   synchronous active-high reset (clears the read register only)
//   en     in   bank enable for this cycle
//   we     in   1 = write wdata at row, 0 = read row into rdata
//   row    in   row address
//   wdata  in   word to write
//   rdata  out  registered read word; holds its value until the next read
module ram_bank #(
  parameter int ROW_WIDTH  = 6,
  parameter int WORD_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  we,
  input  logic [ROW_WIDTH-1:0]  row,
  input  logic [WORD_WIDTH-1:0] wdata,
  output logic [WORD_WIDTH-1:0] rdata
);

  localparam int ROWS = 1 << ROW_WIDTH;

  logic [WORD_WIDTH-1:0] mem_q [ROWS];
  logic [WORD_WIDTH-1:0] rdata_q;
  logic [WORD_WIDTH-1:0] rdata_d;

  // The read register only moves on a read, so a stalled response stays
  // stable without any extra hold logic upstream.
  always_comb begin
    rdata_d = rdata_q;
    if (en && !we) begin
      rdata_d = mem_q[row];
    end
  end

  always_ff @(posedge clk) begin
    if (en && we) begin
      mem_q[row] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/banked_sync_ram.sv
// banked_sync_ram -- banked single-port RAM with valid/ready request and
// response channels, post-reset clear and optional per-word parity.
//
// Address layout: top BANK_BITS of req_addr pick the bank, the remaining
// bits pick the row. After reset the controller spends ROWS cycles writing
// zero to every row of every bank in parallel, then serves requests.
//
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   req_valid  in   request present
//   req_ready  out  request accepted this cycle
//   req_we     in   1 = write, 0 = read
//   req_addr   in   word address
//   req_wdata  in   write data
//   rsp_valid  out  read data available (one cycle after read accept)
//   rsp_ready  in   consumer takes read data
//   rsp_rdata  out  read data
//   rsp_perr   out  parity error on returned word (qualified by rsp_valid)
//   init_done  out  post-reset clear complete
//
// Optional feature: define BANKED_RAM_PARITY_EN to store an even-parity bit
// with every word and check it on read; otherwise rsp_perr is tied low.
module banked_sync_ram
  import banked_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int BANK_BITS  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_perr,
  output logic                  init_done
);

  localparam int NUM_BANKS = 1 << BANK_BITS;
  localparam int ROW_W     = ADDR_WIDTH - BANK_BITS;
`ifdef BANKED_RAM_PARITY_EN
  localparam int WORD_W    = DATA_WIDTH + 1;
`else
  localparam int WORD_W    = DATA_WIDTH;
`endif

  ram_state_e             state_q, state_d;
  logic [ROW_W-1:0]       cnt_q, cnt_d;
  logic                   init_done_q, init_done_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [BANK_BITS-1:0]   rsp_bank_q, rsp_bank_d;

  logic [BANK_BITS-1:0]   req_bank;
  logic [ROW_W-1:0]       req_row;
  logic [NUM_BANKS-1:0]   bank_sel;
  logic [NUM_BANKS-1:0]   bank_en;
  logic                   bank_we;
  logic [ROW_W-1:0]       bank_row;
  logic [WORD_W-1:0]      bank_wdata;
  logic [WORD_W-1:0]      bank_rdata [NUM_BANKS];
  logic [WORD_W-1:0]      rsp_word;
  logic                   clearing;
  logic                   xfer;
  logic [WORD_W-1:0]      req_word;

  assign req_bank = req_addr[ADDR_WIDTH-1 -: BANK_BITS];
  assign req_row  = req_addr[ROW_W-1:0];
  assign clearing = (state_q == CLEAR);

  // A new request is taken only when the response slot is free or being
  // drained this same cycle, giving one read per cycle under full flow.
  assign req_ready = (state_q == IDLE) && (!rsp_valid_q || rsp_ready);
  assign xfer      = req_valid && req_ready;

`ifdef BANKED_RAM_PARITY_EN
  assign req_word = {even_parity(PARITY_MAX_W'(req_wdata)), req_wdata};
`else
  assign req_word = req_wdata;
`endif

  // One-hot bank decode.
  always_comb begin
    bank_sel = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_sel[b] = (req_bank == BANK_BITS'(b));
    end
  end

  // Bank port steering: during CLEAR every bank writes zero at the sweep
  // row (zero data has zero even parity, so an all-zero word is
  // consistent); afterwards only the addressed bank is enabled.
  always_comb begin
    bank_en    = '0;
    bank_we    = req_we;
    bank_row   = req_row;
    bank_wdata = req_word;
    if (clearing) begin
      bank_en    = '1;
      bank_we    = 1'b1;
      bank_row   = cnt_q;
      bank_wdata = '0;
    end else if (xfer) begin
      bank_en = bank_sel;
    end
  end

  // Controller next state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = (state_q == IDLE);
    rsp_valid_d = rsp_valid_q;
    rsp_bank_d  = rsp_bank_q;

    case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (xfer && !req_we) begin
          rsp_valid_d = 1'b1;
          rsp_bank_d  = req_bank;
        end else if (rsp_ready) begin
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLEAR;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_bank_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_bank_q  <= rsp_bank_d;
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    ram_bank #(
      .ROW_WIDTH  (ROW_W),
      .WORD_WIDTH (WORD_W)
    ) u_bank (
      .clk   (clk),
      .rst   (rst),
      .en    (bank_en[g]),
      .we    (bank_we),
      .row   (bank_row),
      .wdata (bank_wdata),
      .rdata (bank_rdata[g])
    );
  end

  // The bank read registers hold their last read, so the mux select only
  // needs to remember which bank served the outstanding read.
  assign rsp_word  = bank_rdata[rsp_bank_q];
  assign rsp_rdata = rsp_word[DATA_WIDTH-1:0];
  assign rsp_valid = rsp_valid_q;
  assign init_done = init_done_q;

`ifdef BANKED_RAM_PARITY_EN
  assign rsp_perr = rsp_word[DATA_WIDTH] ^ even_parity(PARITY_MAX_W'(rsp_word[DATA_WIDTH-1:0]));
`else
  assign rsp_perr = 1'b0;
`endif

endmodule

// File: tb/tb_banked_sync_ram.sv
// tb_banked_sync_ram -- self-checking bench for banked_sync_ram.
// A flat byte array indexed by full address serves as the reference memory;
// the bank/row split is never modelled.
// The parity-deposit step is compiled only with BANKED_RAM_PARITY_EN.
module tb_banked_sync_ram;

  localparam int AW   = 8;
  localparam int DW   = 8;
  localparam int BB   = 2;
  localparam int ROWS = 1 << (AW - BB);

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_perr;
  logic          init_done;

  always #5 clk = ~clk;

  banked_sync_ram #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .BANK_BITS  (BB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_perr  (rsp_perr),
    .init_done (init_done)
  );

  logic [DW-1:0] model [1 << AW];
  int n_vec = 0;
  int n_err = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < (1 << AW); i++) model[i] = '0;
  endtask

  // Counts edges from reset release until init_done is seen; pokes a write
  // during the early clear cycles, which must be refused.
  task automatic wait_init(output int cyc);
    cyc = 0;
    while (!init_done && cyc < 200) begin
      if (cyc < 8) begin
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h25; req_wdata = 8'hFF;
        #1;
        check("ready_in_clear", {31'd0, req_ready}, 32'd0);
      end else begin
        req_valid = 1'b0;
      end
      step();
      cyc++;
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int g;
    g = 0;
    #1;
    while (!req_ready && g < 50) begin
      step();
      g++;
    end
    if (g >= 50) check(tag, {31'd0, req_ready}, 32'd1);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d; rsp_ready = 1'b1;
    wait_ready("wr_ready_timeout");
    step();
    req_valid = 1'b0;
    model[a] = d;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int stalls);
    logic [DW-1:0] exp;
    exp = model[a];
    req_valid = 1'b1; req_we = 1'b0; req_addr = a; rsp_ready = 1'b1;
    wait_ready("rd_ready_timeout");
    step();
    req_valid = 1'b0;
    check("rd_valid", {31'd0, rsp_valid}, 32'd1);
    check("rd_data", {24'd0, rsp_rdata}, {24'd0, exp});
    check("rd_perr", {31'd0, rsp_perr}, 32'd0);
    if (stalls > 0) begin
      rsp_ready = 1'b0;
      for (int s = 0; s < stalls; s++) begin
        step();
        check("stall_valid", {31'd0, rsp_valid}, 32'd1);
        check("stall_data", {24'd0, rsp_rdata}, {24'd0, exp});
      end
      rsp_ready = 1'b1;
    end
  endtask

  initial begin
    int cyc;
    logic [AW-1:0] ba [4];
    logic [AW-1:0] a;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; rsp_ready = 1'b0;
    model_clear();

    // Reset state.
    step(); step(); step();
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
    check("rst_rsp_perr", {31'd0, rsp_perr}, 32'd0);
    check("rst_init_done", {31'd0, init_done}, 32'd0);

    // Clear sweep length.
    rst = 1'b0;
    wait_init(cyc);
    check("init_latency", 32'(cyc), 32'(ROWS + 1));
    #1;
    check("ready_after_init", {31'd0, req_ready}, 32'd1);

    // Memory reads zero after clear, including the refused write target.
    do_read(8'h25, 0);
    do_read(8'h00, 0);
    do_read(8'hFF, 1);
    for (int i = 0; i < 4; i++) do_read(8'($urandom_range(0, 255)), 0);

    // Bank boundary neighbours.
    do_write(8'h3F, 8'hA5);
    do_write(8'h40, 8'h5A);
    do_read(8'h3F, 0);
    do_read(8'h40, 0);
    do_read(8'h3E, 0);
    do_read(8'h41, 0);

    // Back-to-back reads, then a stalled response.
    for (int i = 0; i < 4; i++) begin
      ba[i] = 8'($urandom_range(0, 255));
      do_write(ba[i], 8'($urandom));
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = ba[i];
      step();
      check("b2b_valid", {31'd0, rsp_valid}, 32'd1);
      check("b2b_data", {24'd0, rsp_rdata}, {24'd0, model[ba[i]]});
    end
    a = 8'h3F;
    rsp_ready = 1'b0; req_addr = a;
    #1;
    check("hold_ready", {31'd0, req_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold_data", {24'd0, rsp_rdata}, {24'd0, model[ba[3]]});
      check("hold_ready", {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    step();
    req_valid = 1'b0;
    check("resume_valid", {31'd0, rsp_valid}, 32'd1);
    check("resume_data", {24'd0, rsp_rdata}, {24'd0, model[a]});
    step();
    check("drain_valid", {31'd0, rsp_valid}, 32'd0);

    // Read immediately after write to the same address.
    do_write(8'h80, 8'h11);
    do_read(8'h80, 0);

    // Randomized traffic against the reference array.
    for (int i = 0; i < 80; i++) begin
      a = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) do_write(a, 8'($urandom));
      else do_read(a, int'($urandom_range(0, 2)));
    end

    // Reset during a held response.
    do_write(8'h80, 8'h11);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h80; rsp_ready = 1'b0;
    step();
    req_valid = 1'b0;
    check("pre_rst_valid", {31'd0, rsp_valid}, 32'd1);
    check("pre_rst_data", {24'd0, rsp_rdata}, 32'h11);
    rst = 1'b1;
    step();
    check("midrsp_rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("midrsp_rst_data", {24'd0, rsp_rdata}, 32'd0);
    check("midrsp_rst_init", {31'd0, init_done}, 32'd0);
    check("midrsp_rst_ready", {31'd0, req_ready}, 32'd0);
    rst = 1'b0;
    model_clear();
    wait_init(cyc);
    check("reinit_latency", 32'(cyc), 32'(ROWS + 1));
    do_read(8'h80, 0);
    do_read(8'h3F, 0);

`ifdef BANKED_RAM_PARITY_EN
    // Corrupt a stored data bit behind the parity bit.
    do_write(8'h10, 8'h01);
    step();
    dut.g_bank[0].u_bank.mem_q[16][0] = ~dut.g_bank[0].u_bank.mem_q[16][0];
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10; rsp_ready = 1'b1;
    step();
    req_valid = 1'b0;
    check("perr_valid", {31'd0, rsp_valid}, 32'd1);
    check("perr_data", {24'd0, rsp_rdata}, 32'd0);
    check("perr_flag", {31'd0, rsp_perr}, 32'd1);
    step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
